// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master data-memory/MMIO arbiter: FSM encoding,
// master identifiers, the BRAM address region and the latched request record.
package mem_bus_arbiter_pkg;

    // Transaction FSM encoding: one transaction is IDLE -> ADDR -> DATA -> DONE.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Master identifiers used for owner and last_grant.
    localparam logic MST_CPU = 1'b0;
    localparam logic MST_AUX = 1'b1;

    // The BRAM occupies the region whose top address nibble is zero.
    localparam logic [3:0] BRAM_REGION = 4'h0;

    // Request fields captured from the winning master at the IDLE -> ADDR edge.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_fields_t;

    // True when the top address nibble selects the BRAM region.
    function automatic logic in_bram_region(input logic [3:0] addr_top);
        return addr_top == BRAM_REGION;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and MMIO-decoder signals of the arbiter, bundled as one interface.
// slave  : the arbiter's view (requests in, acks/strobes out).
// master : the environment's view (CPU, aux master and MMIO decoder).
interface mem_bus_arbiter_if;

    // CPU MEM-stage requester
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_stall;

    // Auxiliary requester (program loader / debug reader)
    logic        aux_req;
    logic        aux_we;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdata;
    logic [31:0] aux_rdata;
    logic        aux_ack;
    logic        aux_err;

    // Shared port towards the MMIO decoder
    logic        bus_re;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        output aux_rdata, aux_ack, aux_err,
        output bus_re, bus_we, bus_addr, bus_wdata,
        input  bus_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output aux_req, aux_we, aux_addr, aux_wdata,
        input  aux_rdata, aux_ack, aux_err,
        input  bus_re, bus_we, bus_addr, bus_wdata,
        output bus_rdata
    );

endinterface

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Winner selection for the arbiter. The pick is combinational; last_grant and
// starve_cnt advance only when the FSM commits a grant (commit=1 in IDLE).
module mem_bus_arbiter_arb_pick #(
    parameter bit          CPU_PRIORITY = 1'b1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic aux_req,
    input  logic commit,
    output logic grant
);
    import mem_bus_arbiter_pkg::*;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       last_grant_q;
    logic [3:0] starve_cnt_q;

    // Pick the winner for the current IDLE cycle.
    always_comb begin
        grant = MST_CPU;
        if (cpu_req && aux_req) begin
            if (CPU_PRIORITY) begin
                grant = (starve_cnt_q == LIMIT) ? MST_AUX : MST_CPU;
            end else begin
                grant = (last_grant_q == MST_CPU) ? MST_AUX : MST_CPU;
            end
        end else if (aux_req) begin
            grant = MST_AUX;
        end
    end

    // Record the committed grant and track how long aux has been passed over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // AUX so that the first round-robin tie goes to the CPU.
            last_grant_q <= MST_AUX;
            starve_cnt_q <= 4'd0;
        end else if (commit) begin
            last_grant_q <= grant;
            if (grant == MST_AUX) begin
                starve_cnt_q <= 4'd0;
            end else if (aux_req && (starve_cnt_q != LIMIT)) begin
                starve_cnt_q <= starve_cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the data-memory/MMIO port. Each transaction takes a
// fixed four cycles (IDLE, ADDR, DATA, DONE); the CPU is stalled until its ack.
// Aux accesses outside the BRAM region complete without touching the bus and
// report aux_err.
module mem_bus_arbiter #(
    parameter bit          CPU_PRIORITY = 1'b1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_bus_arbiter_if.slave         bus
);
    import mem_bus_arbiter_pkg::*;

    logic [1:0]  state_q, state_d;
    logic        owner_q;
    req_fields_t fields_q;
    logic        region_ok_q;
    logic [31:0] cpu_rdata_q;
    logic [31:0] aux_rdata_q;

    logic        any_req;
    logic        commit;
    logic        grant;
    req_fields_t win_fields;
    logic        strobe_ok;
    logic        in_done;
    logic [31:0] rd_val;

    assign any_req = bus.cpu_req | bus.aux_req;
    assign commit  = (state_q == ST_IDLE) && any_req;

    mem_bus_arbiter_arb_pick #(
        .CPU_PRIORITY (CPU_PRIORITY),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .cpu_req (bus.cpu_req),
        .aux_req (bus.aux_req),
        .commit  (commit),
        .grant   (grant)
    );

    // Select the winning master's request fields.
    always_comb begin
        win_fields.we    = bus.cpu_we;
        win_fields.addr  = bus.cpu_addr;
        win_fields.wdata = bus.cpu_wdata;
        if (grant == MST_AUX) begin
            win_fields.we    = bus.aux_we;
            win_fields.addr  = bus.aux_addr;
            win_fields.wdata = bus.aux_wdata;
        end
    end

    // Next-state logic: only IDLE waits; the other states advance every cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req) state_d = ST_ADDR;
            ST_ADDR: state_d = ST_DATA;
            ST_DATA: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch owner and request fields when a grant is committed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= MST_CPU;
            fields_q    <= '0;
            region_ok_q <= 1'b1;
        end else if (commit) begin
            owner_q     <= grant;
            fields_q    <= win_fields;
            // The CPU is never filtered; aux is limited to the BRAM region.
            region_ok_q <= (grant == MST_CPU) || in_bram_region(win_fields.addr[31:28]);
        end
    end

    // Out-of-region reads return zero instead of whatever the bus holds.
    assign rd_val = region_ok_q ? bus.bus_rdata : 32'd0;

    // Capture read data into the owner's rdata register in DATA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q <= 32'd0;
            aux_rdata_q <= 32'd0;
        end else if ((state_q == ST_DATA) && !fields_q.we) begin
            if (owner_q == MST_CPU) begin
                cpu_rdata_q <= rd_val;
            end else begin
                aux_rdata_q <= rd_val;
            end
        end
    end

    // Strobes fire only in ADDR; gating with rst drops them the instant reset hits.
    assign strobe_ok     = (state_q == ST_ADDR) && region_ok_q && !rst;
    assign bus.bus_we    = strobe_ok && fields_q.we;
    assign bus.bus_re    = strobe_ok && !fields_q.we;
    assign bus.bus_addr  = fields_q.addr;
    assign bus.bus_wdata = fields_q.wdata;

    assign in_done       = (state_q == ST_DONE) && !rst;
    assign bus.cpu_ack   = in_done && (owner_q == MST_CPU);
    assign bus.aux_ack   = in_done && (owner_q == MST_AUX);
    assign bus.aux_err   = bus.aux_ack && !region_ok_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.aux_rdata = aux_rdata_q;
    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one CPU-priority instance (limit 4) and
// one round-robin instance, driven by hand-written vectors.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if p ();
    mem_bus_arbiter_if r ();

    mem_bus_arbiter #(.CPU_PRIORITY(1'b1), .STARVE_LIMIT(4)) dut_p (
        .clk (clk),
        .rst (rst),
        .bus (p)
    );

    mem_bus_arbiter #(.CPU_PRIORITY(1'b0), .STARVE_LIMIT(4)) dut_r (
        .clk (clk),
        .rst (rst),
        .bus (r)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // One isolated transaction on dut_p, starting from IDLE with no request pending.
    task automatic single_txn(input bit is_aux, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata_in,
                              input bit exp_strobe, input logic [31:0] exp_rdata,
                              input bit exp_err);
        next_cycle();
        if (is_aux) begin
            p.aux_req = 1'b1; p.aux_we = we; p.aux_addr = addr; p.aux_wdata = wdata;
        end else begin
            p.cpu_req = 1'b1; p.cpu_we = we; p.cpu_addr = addr; p.cpu_wdata = wdata;
        end
        sample();                                   // T
        check_eq("t0_stall", p.cpu_stall, !is_aux);
        check_eq("t0_strobe", {p.bus_re, p.bus_we}, 2'b00);
        next_cycle();
        sample();                                   // T+1
        check_eq("t1_re", p.bus_re, exp_strobe && !we);
        check_eq("t1_we", p.bus_we, exp_strobe && we);
        if (exp_strobe) begin
            check_eq("t1_addr", p.bus_addr, addr);
            if (we) check_eq("t1_wdata", p.bus_wdata, wdata);
        end
        next_cycle();
        p.bus_rdata = rdata_in;
        sample();                                   // T+2
        check_eq("t2_strobe", {p.bus_re, p.bus_we}, 2'b00);
        check_eq("t2_stall", p.cpu_stall, !is_aux);
        next_cycle();
        sample();                                   // T+3
        check_eq("t3_cpu_ack", p.cpu_ack, !is_aux);
        check_eq("t3_aux_ack", p.aux_ack, is_aux);
        check_eq("t3_aux_err", p.aux_err, exp_err);
        check_eq("t3_stall", p.cpu_stall, 1'b0);
        if (!we) check_eq("t3_rdata", is_aux ? p.aux_rdata : p.cpu_rdata, exp_rdata);
        next_cycle();
        p.cpu_req = 1'b0;
        p.aux_req = 1'b0;
        sample();                                   // T+4
        check_eq("t4_acks", {p.cpu_ack, p.aux_ack, p.aux_err}, 3'b000);
    endtask

    // Wait (bounded) for the next ack on the chosen instance.
    task automatic wait_ack(input bit use_rr, output bit ca, output bit aa, output int cyc);
        bit got = 1'b0;
        cyc = 0;
        ca = 1'b0;
        aa = 1'b0;
        while (!got && cyc < 8) begin
            next_cycle();
            sample();
            cyc++;
            ca = use_rr ? r.cpu_ack : p.cpu_ack;
            aa = use_rr ? r.aux_ack : p.aux_ack;
            got = ca | aa;
        end
        check_eq("ack_seen", got, 1'b1);
    endtask

    bit exp_aux_p [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int exp_cnt_p [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    bit exp_aux_r [4]  = '{0, 1, 0, 1};

    initial begin
        bit ca, aa, aux_seen;
        int cyc;

        p.cpu_req = 0; p.cpu_we = 0; p.cpu_addr = 0; p.cpu_wdata = 0;
        p.aux_req = 0; p.aux_we = 0; p.aux_addr = 0; p.aux_wdata = 0; p.bus_rdata = 0;
        r.cpu_req = 0; r.cpu_we = 0; r.cpu_addr = 0; r.cpu_wdata = 0;
        r.aux_req = 0; r.aux_we = 0; r.aux_addr = 0; r.aux_wdata = 0; r.bus_rdata = 0;

        // Reset state
        repeat (2) @(posedge clk);
        sample();
        check_eq("rst_outs", {p.cpu_ack, p.aux_ack, p.aux_err, p.bus_re, p.bus_we}, 5'b0);
        check_eq("rst_bus_addr", p.bus_addr, 32'd0);
        check_eq("rst_bus_wdata", p.bus_wdata, 32'd0);
        check_eq("rst_cpu_rdata", p.cpu_rdata, 32'd0);
        check_eq("rst_aux_rdata", p.aux_rdata, 32'd0);
        check_eq("rst_state", dut_p.state_q, 2'd0);
        check_eq("rst_owner", dut_p.owner_q, 1'b0);
        check_eq("rst_last_grant", dut_p.u_arb.last_grant_q, 1'b1);
        check_eq("rst_starve", dut_p.u_arb.starve_cnt_q, 4'd0);
        next_cycle();
        rst = 1'b0;

        // CPU read, aux write, aux read, aux out-of-region read
        single_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0);
        single_txn(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0, 1'b1, 32'h0, 1'b0);
        single_txn(1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0);
        single_txn(1'b1, 1'b0, 32'h2000_0000, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1);

        // CPU priority with starvation protection: C,C,C,C,A,C,C,C,C,A
        next_cycle();
        p.cpu_req = 1'b1; p.cpu_we = 1'b0; p.cpu_addr = 32'h4;
        p.aux_req = 1'b1; p.aux_we = 1'b0; p.aux_addr = 32'h8;
        for (int k = 0; k < 10; k++) begin
            wait_ack(1'b0, ca, aa, cyc);
            check_eq($sformatf("prio_grant%0d", k), {ca, aa}, {!exp_aux_p[k], exp_aux_p[k]});
            check_eq($sformatf("prio_starve%0d", k), dut_p.u_arb.starve_cnt_q, exp_cnt_p[k]);
            if (k > 0) check_eq($sformatf("prio_gap%0d", k), cyc, 4);
        end
        next_cycle();
        p.cpu_req = 1'b0;
        p.aux_req = 1'b0;

        // Round robin: C,A,C,A with acks every 4 cycles
        r.cpu_req = 1'b1; r.cpu_addr = 32'h14;
        r.aux_req = 1'b1; r.aux_addr = 32'h18;
        for (int k = 0; k < 4; k++) begin
            wait_ack(1'b1, ca, aa, cyc);
            check_eq($sformatf("rr_grant%0d", k), {ca, aa}, {!exp_aux_r[k], exp_aux_r[k]});
            if (k > 0) check_eq($sformatf("rr_gap%0d", k), cyc, 4);
        end
        next_cycle();
        r.cpu_req = 1'b0;
        r.aux_req = 1'b0;

        // Reset during an aux write ADDR cycle, with a CPU read held across reset
        sample();
        next_cycle();
        p.aux_req = 1'b1; p.aux_we = 1'b1; p.aux_addr = 32'h44; p.aux_wdata = 32'h55AA_55AA;
        sample();
        next_cycle();
        sample();
        check_eq("mr_we_before", p.bus_we, 1'b1);
        rst = 1'b1;
        p.aux_req = 1'b0;
        p.cpu_req = 1'b1; p.cpu_we = 1'b0; p.cpu_addr = 32'h8;
        #1;
        check_eq("mr_we_dropped", p.bus_we, 1'b0);
        check_eq("mr_aux_ack", p.aux_ack, 1'b0);
        check_eq("mr_bus_addr", p.bus_addr, 32'd0);
        next_cycle();
        rst = 1'b0;
        p.bus_rdata = 32'h0BAD_F00D;
        aux_seen = 1'b0;
        sample();                                   // R: IDLE, cpu_req held
        aux_seen |= p.aux_ack;
        check_eq("mr_r0_ack", p.cpu_ack, 1'b0);
        next_cycle();
        sample();                                   // R+1
        aux_seen |= p.aux_ack;
        check_eq("mr_r1_re", p.bus_re, 1'b1);
        check_eq("mr_r1_addr", p.bus_addr, 32'h8);
        next_cycle();
        sample();                                   // R+2
        aux_seen |= p.aux_ack;
        next_cycle();
        sample();                                   // R+3
        aux_seen |= p.aux_ack;
        check_eq("mr_r3_ack", p.cpu_ack, 1'b1);
        check_eq("mr_r3_rdata", p.cpu_rdata, 32'h0BAD_F00D);
        check_eq("mr_no_aux_ack", aux_seen, 1'b0);
        next_cycle();
        p.cpu_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
